// File: rtl/regfile_mp_if.sv
// rtl/regfile_mp_if.sv - write, read and scoreboard bundle for the multi-port register file
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic                     we0;
  logic [ADDR_W-1:0]        waddr0;
  logic [DATA_W-1:0]        wdata0;
  logic                     we1;
  logic [ADDR_W-1:0]        waddr1;
  logic [DATA_W-1:0]        wdata1;
  logic [NUM_RD-1:0]        re;
  logic [NUM_RD*ADDR_W-1:0] raddr;
  logic [NUM_RD*DATA_W-1:0] rdata;
  logic                     set_busy;
  logic [ADDR_W-1:0]        set_addr;
  logic [NUM_RD-1:0]        busy;

  modport master (
    output we0, waddr0, wdata0, we1, waddr1, wdata1,
    output re, raddr, set_busy, set_addr,
    input  rdata, busy
  );

  modport slave (
    input  we0, waddr0, wdata0, we1, waddr1, wdata1,
    input  re, raddr, set_busy, set_addr,
    output rdata, busy
  );
endinterface

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file, 2 write ports, bypass, optional busy scoreboard (REGFILE_SCOREBOARD_EN)
module regfile_mp #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NUM_RD  = 2,
  parameter int ZERO_R0 = 1
) (
  input  logic        clk,
  input  logic        rst,
  regfile_mp_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];

  // A write is effective only if enabled and not aimed at a hardwired zero register
  logic wr0_ok;
  logic wr1_ok;
  assign wr0_ok = bus.we0 && !((ZERO_R0 != 0) && (bus.waddr0 == '0));
  assign wr1_ok = bus.we1 && !((ZERO_R0 != 0) && (bus.waddr1 == '0));

  // Storage update; port 1 is assigned last so it wins a same-address dual write
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) regs[k] <= '0;
    end else begin
      if (wr0_ok) regs[bus.waddr0] <= bus.wdata0;
      if (wr1_ok) regs[bus.waddr1] <= bus.wdata1;
    end
  end

`ifdef REGFILE_SCOREBOARD_EN
  logic [DEPTH-1:0] busy_q;
  logic             set_ok;
  assign set_ok = bus.set_busy && !((ZERO_R0 != 0) && (bus.set_addr == '0));

  // Busy bits: writes clear, set is applied last so a new producer wins a collision
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      if (bus.we0) busy_q[bus.waddr0] <= 1'b0;
      if (bus.we1) busy_q[bus.waddr1] <= 1'b0;
      if (set_ok)  busy_q[bus.set_addr] <= 1'b1;
    end
  end
`else
  logic unused_sb;
  assign unused_sb = ^{bus.set_busy, bus.set_addr};
  assign bus.busy  = '0;
`endif

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              zero_hit;
    logic              hit0;
    logic              hit1;
    logic [DATA_W-1:0] rd_val;

    assign ra       = bus.raddr[i*ADDR_W +: ADDR_W];
    assign zero_hit = (ZERO_R0 != 0) && (ra == '0);
    assign hit0     = wr0_ok && (bus.waddr0 == ra);
    assign hit1     = wr1_ok && (bus.waddr1 == ra);

    // Read mux: masked reads first, then the younger in-flight write, older write, storage
    always_comb begin
      rd_val = regs[ra];
      if (rst || !bus.re[i] || zero_hit) rd_val = '0;
      else if (hit1)                     rd_val = bus.wdata1;
      else if (hit0)                     rd_val = bus.wdata0;
    end

    assign bus.rdata[i*DATA_W +: DATA_W] = rd_val;

`ifdef REGFILE_SCOREBOARD_EN
    // Any same-cycle write to the operand satisfies it through the bypass
    assign bus.busy[i] = !rst && bus.re[i] && busy_q[ra]
                         && !(bus.we0 && (bus.waddr0 == ra))
                         && !(bus.we1 && (bus.waddr1 == ra));
`endif
  end
endmodule
